// File: rtl/sht_frame_checker.sv
// SHT40 receive-frame checker: bit-serial CRC-8 over each T/RH group, publishes raw words on a full pass.
// Optional build macro SHT_CRC_STICKY_EN makes crc_error a held level instead of a one-cycle pulse.
module sht_frame_checker #(
    parameter logic [7:0] CRC_POLY = 8'h31,
    parameter logic [7:0] CRC_INIT = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        busy,
    output logic [2:0]  byte_index,
    output logic [15:0] temp_raw,
    output logic [15:0] rh_raw,
    output logic        data_valid,
    output logic        crc_error
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, HALT} state_t;

    state_t      state, state_d;
    logic [7:0]  crc, crc_d;
    logic [7:0]  sreg, sreg_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [2:0]  index_d;
    logic [15:0] stage_t, stage_t_d;
    logic [15:0] stage_h, stage_h_d;
    logic [15:0] temp_d, rh_d;
    logic        data_valid_d, crc_error_d;
    logic        fb;
    logic [7:0]  crc_step;
    logic        group_end;
    logic        overrun;

    assign fb        = crc[7] ^ sreg[7];
    assign crc_step  = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    assign group_end = (byte_index == 3'd2) || (byte_index == 3'd5);
    assign overrun   = byte_valid && ((state == SHIFT) || (state == CHECK));
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            crc        <= CRC_INIT;
            sreg       <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_index <= 3'd0;
            stage_t    <= 16'h0000;
            stage_h    <= 16'h0000;
            temp_raw   <= 16'h0000;
            rh_raw     <= 16'h0000;
            data_valid <= 1'b0;
            crc_error  <= 1'b0;
        end else begin
            state      <= state_d;
            crc        <= crc_d;
            sreg       <= sreg_d;
            bit_cnt    <= bit_cnt_d;
            byte_index <= index_d;
            stage_t    <= stage_t_d;
            stage_h    <= stage_h_d;
            temp_raw   <= temp_d;
            rh_raw     <= rh_d;
            data_valid <= data_valid_d;
            crc_error  <= crc_error_d;
        end
    end

    always_comb begin
        state_d      = state;
        crc_d        = crc;
        sreg_d       = sreg;
        bit_cnt_d    = bit_cnt;
        index_d      = byte_index;
        stage_t_d    = stage_t;
        stage_h_d    = stage_h;
        temp_d       = temp_raw;
        rh_d         = rh_raw;
        data_valid_d = 1'b0;
`ifdef SHT_CRC_STICKY_EN
        crc_error_d  = crc_error;
`else
        crc_error_d  = 1'b0;
`endif

        if (frame_start) begin
            state_d     = IDLE;
            index_d     = 3'd0;
            crc_d       = CRC_INIT;
            bit_cnt_d   = 3'd0;
            stage_t_d   = 16'h0000;
            stage_h_d   = 16'h0000;
            crc_error_d = 1'b0;
        end else if (overrun) begin
            state_d     = HALT;
            crc_error_d = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        sreg_d    = byte_data;
                        bit_cnt_d = 3'd0;
                        state_d   = SHIFT;
                        case (byte_index)
                            3'd0:    stage_t_d[15:8] = byte_data;
                            3'd1:    stage_t_d[7:0]  = byte_data;
                            3'd3:    stage_h_d[15:8] = byte_data;
                            3'd4:    stage_h_d[7:0]  = byte_data;
                            default: ;
                        endcase
                    end
                end
                SHIFT: begin
                    crc_d     = crc_step;
                    sreg_d    = {sreg[6:0], 1'b0};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        // Verdict is registered on entry to CHECK so outputs appear during CHECK.
                        if (group_end) begin
                            state_d = CHECK;
                            if (crc_step != 8'h00) begin
                                crc_error_d = 1'b1;
                            end else if (byte_index == 3'd5) begin
                                temp_d       = stage_t;
                                rh_d         = stage_h;
                                data_valid_d = 1'b1;
                            end
                        end else begin
                            index_d = byte_index + 3'd1;
                            state_d = IDLE;
                        end
                    end
                end
                CHECK: begin
                    if (crc == 8'h00) begin
                        crc_d   = CRC_INIT;
                        index_d = (byte_index == 3'd5) ? 3'd0 : 3'd3;
                        state_d = IDLE;
                    end else begin
                        state_d = HALT;
                    end
                end
                HALT:    ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: doc/sht_frame_checker.md
Name: sht_frame_checker

Overview:
- Downstream consumer of the I2C master's receive path for the SHT40 read sequence.
- Takes the six received bytes one at a time: T_msb, T_lsb, T_crc, RH_msb, RH_lsb, RH_crc.
- Runs a bit-serial CRC-8 over each 2-byte word plus its CRC byte, assembles 16-bit raw temperature and humidity words, and publishes them once both words check.
- Its crc_error output drives the master's CRC_Error input, aborting the receive.

Parameters:
- CRC_POLY, 8'h31, CRC-8 generator polynomial (x^8+x^5+x^4+1), MSB-first.
- CRC_INIT, 8'hFF, CRC register value at the start of each 3-byte group.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  one-cycle pulse; aborts any frame in progress and arms for byte 0.
- byte_valid  input  1  one-cycle pulse; byte_data is a received byte.
- byte_data  input  8  received byte, MSB = first bit on the bus.
- busy  output  1  high while the CRC shift engine is processing a byte.
- byte_index  output  3  index (0-5) of the next byte expected.
- temp_raw  output  16  last validated temperature word.
- rh_raw  output  16  last validated humidity word.
- data_valid  output  1  one-cycle pulse: both words passed CRC and were updated.
- crc_error  output  1  CRC failure or overrun indication (see Optional Feature).

Behaviour:
- Reset values: busy=0, byte_index=0, temp_raw=16'h0000, rh_raw=16'h0000, data_valid=0, crc_error=0. Internally: crc register=CRC_INIT, state=IDLE.
- States: IDLE, SHIFT, CHECK, HALT.
- IDLE:
  - A byte_valid at cycle t latches byte_data into the shift register, stores it in a staging slot by byte_index, and enters SHIFT at t+1.
- SHIFT:
  - busy=1. Runs exactly 8 cycles (t+1..t+8), one bit per cycle, MSB first.
  - Per cycle: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - After 8 cycles: enter CHECK if byte_index is 2 or 5; otherwise increment byte_index and return to IDLE.
- CHECK (cycle t+9):
  - Because the CRC byte is shifted through the register too, a good group leaves crc==8'h00.
  - Pass on byte 2: keep the T word in staging, reload crc=CRC_INIT, byte_index=3, return to IDLE.
  - Pass on byte 5: in the same cycle copy both staged words to temp_raw/rh_raw, pulse data_valid, set byte_index=0, reload crc, return to IDLE.
  - Fail on either group: pulse crc_error, leave temp_raw/rh_raw unchanged, enter HALT.
- HALT:
  - All byte_valid pulses are ignored. Exit only via frame_start or reset.
- Outputs are updated only on a full 6-byte pass; a partial frame never changes them.
- Overrun:
  - A byte_valid while busy=1 or in CHECK drops the byte.
  - It raises crc_error the next cycle and enters HALT.
- frame_start:
  - Valid in any state; takes priority over a byte_valid in the same cycle.
  - Next cycle: IDLE, byte_index=0, crc=CRC_INIT, crc_error cleared, staging cleared.
  - temp_raw/rh_raw are preserved.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
- byte_index never exceeds 5; it wraps to 0 only via a byte-5 pass, frame_start, or reset.

Optional Feature:
- Macro: SHT_CRC_STICKY_EN.
- Defined: crc_error is a level, set by a CRC fail or overrun and held until frame_start or reset. This suits a master that samples CRC_Error only on SCL edges.
- Undefined: crc_error is a single-cycle pulse. HALT behaviour is identical in both builds.

Test Plan:
- Reset, then frame_start, then bytes BE,EF,92,BE,EF,92 spaced 40 cycles apart -> data_valid pulses exactly 9 cycles after the last byte_valid; temp_raw=16'hBEEF, rh_raw=16'hBEEF; crc_error never asserted.
- Bytes BE,EF,93 -> crc_error asserted 9 cycles after the third byte; byte_index stays at 2; following bytes ignored; outputs keep their prior values.
- After a good frame, send a frame whose RH CRC is bad -> temp_raw/rh_raw still hold the previous values; no data_valid.
- Second byte_valid 3 cycles after the first -> byte dropped; crc_error the next cycle; HALT; frame_start then the good sequence -> recovers with data_valid.
- frame_start and byte_valid in the same cycle while at byte_index=4 -> byte_index=0; the byte is discarded.
- rst_n low during SHIFT -> busy=0 and byte_index=0 asynchronously; good frame after release passes. Repeat the crc_error checks with and without SHT_CRC_STICKY_EN (level vs one-cycle pulse).
